// File: rtl/seg7_scan.sv
// Time-multiplexed N-digit hex 7-segment driver with a dead cycle between digit slots.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] sh_value;
    logic [DIGITS-1:0]   sh_blank;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;

    logic [DIGITS-1:0]   eff_blank;
    logic [3:0]          nib;
    logic                nib_blank;
    logic [DIGITS-1:0]   an_next;
    logic [6:0]          seg_next;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h18;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        eff_blank = sh_blank;
`ifdef SEG7_SCAN_LZB_EN
        begin
            logic zero_run;
            zero_run = 1'b1;
            // Walk down from the most significant digit; digit 0 is never blanked here.
            for (int i = DIGITS - 1; i > 0; i--) begin
                zero_run = zero_run & (sh_value[4*i +: 4] == 4'h0);
                if (zero_run) eff_blank[i] = 1'b1;
            end
        end
`endif
        nib       = 4'h0;
        nib_blank = 1'b0;
        an_next   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = sh_value[4*i +: 4];
                nib_blank = eff_blank[i];
                if (cnt != '0) an_next[i] = 1'b0;
            end
        end
        // cnt == 0 is the dead cycle of each slot.
        seg_next = (cnt == '0 || nib_blank) ? 7'h7F : decode(nib);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_value <= '0;
            sh_blank <= '0;
            cnt      <= '0;
            idx      <= '0;
            seg      <= 7'h7F;
            an       <= '1;
        end else begin
            if (load) begin
                sh_value <= value;
                sh_blank <= blank;
            end
            if (cnt == CW'(PRESCALE - 1)) begin
                cnt <= '0;
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan (DIGITS=4, PRESCALE=4) with a per-cycle expected queue.
module tb_seg7_scan;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  blank = 4'h0;
    logic [6:0]  seg;
    logic [3:0]  an;

    seg7_scan #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .blank(blank),
        .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    logic [10:0] exp_q[$];
    logic [6:0]  dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0]  an_seq [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                 4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

    int          vectors = 0;
    int          miscompares = 0;

    // Reference state: cycles since reset release and the shadow contents.
    int          pos = 0;
    logic [15:0] m_shadow = 16'h0;
    logic [3:0]  m_blank = 4'h0;

    function automatic logic lz_blank(input int d, input logic [15:0] sh);
`ifdef SEG7_SCAN_LZB_EN
        return (d > 0) && ((sh >> (4 * d)) == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] b);
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic [10:0] got, e;
        int          slot, d;
        rst = r; load = ld; value = v; blank = b;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        if (!r) begin
            slot = pos % PRESCALE;
            d    = (pos / PRESCALE) % DIGITS;
            if (slot != 0) begin
                e_an  = ~(4'b0001 << d);
                e_seg = (m_blank[d] || lz_blank(d, m_shadow)) ? 7'h7F : dec_tab[m_shadow[4*d +: 4]];
            end
        end
        exp_q.push_back({e_an, e_seg});
        @(posedge clk);
        #1;
        got = {an, seg};
        e   = exp_q.pop_front();
        vectors++;
        assert (got === e) else begin
            miscompares++;
            $error("FAIL out pos=%0d an/seg got %h/%h exp %h/%h", pos, got[10:7], got[6:0], e[10:7], e[6:0]);
        end
        vectors++;
        assert (($countones(~an) <= 1) === 1'b1) else begin
            miscompares++;
            $error("FAIL onehot an got %h exp at most one low bit", an);
        end
        if (r) begin
            pos = 0; m_shadow = 16'h0; m_blank = 4'h0;
        end else begin
            if (ld) begin
                m_shadow = v; m_blank = b;
            end
            pos++;
        end
        @(negedge clk);
    endtask

    function automatic logic at_slot(input int digit, input int s);
        return ((pos / PRESCALE) % DIGITS == digit) && (pos % PRESCALE == s);
    endfunction

    initial begin
        // Reset held for three cycles.
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b1, 16'hFFFF, 4'h0);

        // First frame: explicit an sequence on top of the model.
        for (int k = 0; k < 16; k++) begin
            tick(1'b0, 1'b0, 16'h0, 4'h0);
            vectors++;
            assert (an === an_seq[k]) else begin
                miscompares++;
                $error("FAIL an_seq[%0d] got %h exp %h", k, an, an_seq[k]);
            end
        end

        // One-cycle load of 1234, then FFFF presented without load.
        tick(1'b0, 1'b1, 16'h1234, 4'h0);
        for (int k = 0; k < 20; k++) tick(1'b0, 1'b0, 16'hFFFF, 4'h0);

        // Load ABCD in the middle of digit 1's slot.
        for (int k = 0; k < 64 && !at_slot(1, 2); k++) tick(1'b0, 1'b0, 16'hFFFF, 4'h0);
        tick(1'b0, 1'b1, 16'hABCD, 4'h0);
        for (int k = 0; k < 18; k++) tick(1'b0, 1'b0, 16'h5555, 4'h0);

        // Forced blank of digits 0 and 2.
        tick(1'b0, 1'b1, 16'h8888, 4'b0101);
        for (int k = 0; k < 18; k++) tick(1'b0, 1'b0, 16'h0, 4'hF);

        // Reset pulse mid-way through digit 2's slot, with load asserted alongside.
        for (int k = 0; k < 64 && !at_slot(2, 2); k++) tick(1'b0, 1'b0, 16'h0, 4'h0);
        tick(1'b1, 1'b1, 16'h9999, 4'h0);
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b0, 16'h0, 4'h0);

        // Leading-zero patterns (expectations depend on the build option).
        tick(1'b0, 1'b1, 16'h0040, 4'h0);
        for (int k = 0; k < 17; k++) tick(1'b0, 1'b0, 16'h0, 4'h0);
        tick(1'b0, 1'b1, 16'h0000, 4'h0);
        for (int k = 0; k < 17; k++) tick(1'b0, 1'b0, 16'h0, 4'h0);

        // Load held high tracks value every cycle.
        for (int k = 0; k < 24; k++) tick(1'b0, 1'b1, 16'($urandom_range(0, 16'hFFFF)), 4'($urandom_range(0, 15)));
        for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 16'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
